// File: rtl/vga_timing_gen_if.sv
// Shadow-register config bus for vga_timing_gen.
// master: register block side; slave: timing generator side.
interface vga_timing_gen_if #(
  parameter int CW = 12
);
  logic          cfg_we;
  logic [3:0]    cfg_sel;
  logic [CW-1:0] cfg_wdata;
  logic          cfg_commit;
  logic          cfg_busy;

  modport master (
    output cfg_we,
    output cfg_sel,
    output cfg_wdata,
    output cfg_commit,
    input  cfg_busy
  );

  modport slave (
    input  cfg_we,
    input  cfg_sel,
    input  cfg_wdata,
    input  cfg_commit,
    output cfg_busy
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Programmable raster timing generator: fetch coords + delayed sync/de.
// Ports: clock/reset/enable, cfg bus (slave), fetch_*, scanline, vblank, irqs, hsync/vsync/de.
module vga_timing_gen #(
  parameter int CW       = 12,
  parameter int PIPE     = 2,
  parameter int H_ACTIVE = 1280,
  parameter int H_FRONT  = 80,
  parameter int H_SYNC   = 136,
  parameter int H_BACK   = 216,
  parameter int V_ACTIVE = 960,
  parameter int V_FRONT  = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 30,
  parameter int X_SHIFT  = 1,
  parameter int Y_SHIFT  = 1,
  parameter bit HS_ACT_HIGH = 1'b0,
  parameter bit VS_ACT_HIGH = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  vga_timing_gen_if.slave cfg,
  output logic          fetch_valid,
  output logic [CW-1:0] fetch_x,
  output logic [CW-1:0] fetch_y,
  output logic [CW-1:0] scanline,
  output logic          vblank,
  output logic          frame_start,
  output logic          line_irq,
  output logic          hsync,
  output logic          vsync,
  output logic          de
);

  localparam logic [CW-1:0] TM_DEF [8] = '{
    CW'(H_ACTIVE), CW'(H_FRONT), CW'(H_SYNC), CW'(H_BACK),
    CW'(V_ACTIVE), CW'(V_FRONT), CW'(V_SYNC), CW'(V_BACK)
  };

  logic [CW-1:0] sh_tm   [8];
  logic [CW-1:0] sh_tm_n [8];
  logic [CW-1:0] lv_tm   [8];
  logic [2:0]    sh_xs, sh_ys, sh_xs_n, sh_ys_n;
  logic [2:0]    lv_xs, lv_ys;
  logic [CW-1:0] sh_irq, sh_irq_n, lv_irq;
  logic          pend;
  logic [CW-1:0] x, y;
  logic [CW-1:0] h_total, v_total;
  logic [CW-1:0] hs_beg, hs_end, vs_beg, vs_end;
  logic          x_last, y_last, load;
  logic          hs_act, vs_act;
  logic [2:0]    pipe [PIPE];
  logic [2:0]    p_out;

  assign h_total = lv_tm[0] + lv_tm[1] + lv_tm[2] + lv_tm[3];
  assign v_total = lv_tm[4] + lv_tm[5] + lv_tm[6] + lv_tm[7];
  assign hs_beg  = lv_tm[0] + lv_tm[1];
  assign hs_end  = hs_beg + lv_tm[2];
  assign vs_beg  = lv_tm[4] + lv_tm[5];
  assign vs_end  = vs_beg + lv_tm[6];

  assign x_last = (x == h_total - CW'(1));
  assign y_last = (y == v_total - CW'(1));

  // Live set swaps only at the frame wrap, or at once while stopped.
  assign load = pend && (!enable || (x_last && y_last));

  assign fetch_valid = enable && (x < lv_tm[0]) && (y < lv_tm[4]);
  assign fetch_x     = x >> lv_xs;
  assign fetch_y     = y >> lv_ys;
  assign scanline    = fetch_valid ? y : '0;
  assign vblank      = (y >= lv_tm[4]);
  assign frame_start = enable && (x == '0) && (y == '0);
  assign line_irq    = enable && (x == '0) && (y == lv_irq);

  assign hs_act = (x >= hs_beg) && (x < hs_end);
  assign vs_act = (y >= vs_beg) && (y < vs_end);

  assign p_out = pipe[PIPE-1];
  assign de    = p_out[2];
  assign hsync = HS_ACT_HIGH ? p_out[1] : ~p_out[1];
  assign vsync = VS_ACT_HIGH ? p_out[0] : ~p_out[0];

  assign cfg.cfg_busy = pend;

  // Shadow as it will be after this cycle's write, so a write
  // landing on the load edge is still taken by the commit.
  always_comb begin
    sh_tm_n  = sh_tm;
    sh_xs_n  = sh_xs;
    sh_ys_n  = sh_ys;
    sh_irq_n = sh_irq;
    if (cfg.cfg_we) begin
      unique case (1'b1)
        !cfg.cfg_sel[3]: begin
          sh_tm_n[cfg.cfg_sel[2:0]] =
            (cfg.cfg_wdata == '0) ? CW'(1) : cfg.cfg_wdata;
        end
        cfg.cfg_sel == 4'd8: begin
          sh_xs_n = cfg.cfg_wdata[2:0];
          sh_ys_n = cfg.cfg_wdata[6:4];
        end
        cfg.cfg_sel == 4'd9: begin
          sh_irq_n = cfg.cfg_wdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x      <= '0;
      y      <= '0;
      pend   <= 1'b0;
      sh_xs  <= 3'(X_SHIFT);
      sh_ys  <= 3'(Y_SHIFT);
      lv_xs  <= 3'(X_SHIFT);
      lv_ys  <= 3'(Y_SHIFT);
      sh_irq <= '0;
      lv_irq <= '0;
      for (int i = 0; i < 8; i++) begin
        sh_tm[i] <= TM_DEF[i];
        lv_tm[i] <= TM_DEF[i];
      end
      for (int i = 0; i < PIPE; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      sh_tm  <= sh_tm_n;
      sh_xs  <= sh_xs_n;
      sh_ys  <= sh_ys_n;
      sh_irq <= sh_irq_n;
      pend   <= !load && (pend || cfg.cfg_commit);
      if (load) begin
        lv_tm  <= sh_tm_n;
        lv_xs  <= sh_xs_n;
        lv_ys  <= sh_ys_n;
        lv_irq <= sh_irq_n;
      end
      if (!enable) begin
        x <= '0;
        y <= '0;
      end else if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : y + CW'(1);
      end else begin
        x <= x + CW'(1);
      end
      if (!enable) begin
        for (int i = 0; i < PIPE; i++) begin
          pipe[i] <= '0;
        end
      end else begin
        pipe[0] <= {fetch_valid, hs_act, vs_act};
        for (int i = 1; i < PIPE; i++) begin
          pipe[i] <= pipe[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: frame-time reference model,
// constant table for a small frame, directed corner sequences, random traffic.
module tb_vga_timing_gen;

  localparam int CW   = 12;
  localparam int PIPE = 2;

  logic          clock;
  logic          reset;
  logic          enable;
  logic          fetch_valid;
  logic [CW-1:0] fetch_x, fetch_y, scanline;
  logic          vblank, frame_start, line_irq;
  logic          hsync, vsync, de;

  vga_timing_gen_if #(.CW(CW)) cfg_bus ();

  vga_timing_gen #(.CW(CW), .PIPE(PIPE)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .cfg         (cfg_bus.slave),
    .fetch_valid (fetch_valid),
    .fetch_x     (fetch_x),
    .fetch_y     (fetch_y),
    .scanline    (scanline),
    .vblank      (vblank),
    .frame_start (frame_start),
    .line_irq    (line_irq),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int errors;
  int checks;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: position is the cycle count within the frame.
  int         m_t;
  int         m_tm [8];
  int         s_tm [8];
  int         m_xs, m_ys, s_xs, s_ys, m_irq, s_irq;
  bit         m_pend;
  logic [2:0] m_hist [$];

  task automatic hist_clear();
    m_hist = {};
    for (int i = 0; i < PIPE; i++) m_hist.push_back(3'b000);
  endtask

  task automatic model_reset();
    m_tm = '{1280, 80, 136, 216, 960, 1, 3, 30};
    s_tm = m_tm;
    m_xs = 1; m_ys = 1; s_xs = 1; s_ys = 1;
    m_irq = 0; s_irq = 0;
    m_pend = 0;
    m_t = 0;
    hist_clear();
  endtask

  function automatic logic [43:0] model_out();
    int ht, x, y;
    logic fv;
    logic [2:0] h;
    ht = m_tm[0] + m_tm[1] + m_tm[2] + m_tm[3];
    x  = m_t % ht;
    y  = m_t / ht;
    fv = enable && (x < m_tm[0]) && (y < m_tm[4]);
    h  = m_hist[0];
    return {m_pend, fv, 12'(x >> m_xs), 12'(y >> m_ys),
            fv ? 12'(y) : 12'd0, (y >= m_tm[4]),
            enable && (m_t == 0), enable && (x == 0) && (y == m_irq),
            ~h[1], h[0], h[2]};
  endfunction

  task automatic model_edge();
    int ht, vt, x, y, wd, s, hb, vb;
    logic load;
    logic [2:0] cur;
    if (reset) begin
      model_reset();
      return;
    end
    ht = m_tm[0] + m_tm[1] + m_tm[2] + m_tm[3];
    vt = m_tm[4] + m_tm[5] + m_tm[6] + m_tm[7];
    x  = m_t % ht;
    y  = m_t / ht;
    hb = m_tm[0] + m_tm[1];
    vb = m_tm[4] + m_tm[5];
    cur = {(x < m_tm[0]) && (y < m_tm[4]),
           (x >= hb) && (x < hb + m_tm[2]),
           (y >= vb) && (y < vb + m_tm[6])};
    wd = int'(cfg_bus.cfg_wdata);
    s  = int'(cfg_bus.cfg_sel);
    if (cfg_bus.cfg_we) begin
      if (s < 8) s_tm[s] = (wd == 0) ? 1 : wd;
      else if (s == 8) begin
        s_xs = wd & 7;
        s_ys = (wd >> 4) & 7;
      end else if (s == 9) s_irq = wd;
    end
    load = m_pend && (!enable || (m_t == ht * vt - 1));
    if (!enable) begin
      m_t = 0;
      hist_clear();
    end else begin
      m_t = (m_t == ht * vt - 1) ? 0 : m_t + 1;
      m_hist.push_back(cur);
      void'(m_hist.pop_front());
    end
    if (load) begin
      m_tm = s_tm; m_xs = s_xs; m_ys = s_ys; m_irq = s_irq;
    end
    m_pend = !load && (m_pend || cfg_bus.cfg_commit);
  endtask

  // Outputs sampled in the most recent step.
  logic          s_busy, s_fv, s_vb, s_fs, s_li, s_hs, s_vs, s_de;
  logic [CW-1:0] s_fx, s_fy, s_sc;

  task automatic step(input bit r, input bit e, input bit w,
                      input int s, input int d, input bit c);
    logic [43:0] act;
    @(negedge clock);
    reset              = r;
    enable             = e;
    cfg_bus.cfg_we     = w;
    cfg_bus.cfg_sel    = 4'(s);
    cfg_bus.cfg_wdata  = 12'(d);
    cfg_bus.cfg_commit = c;
    #1;
    s_busy = cfg_bus.cfg_busy; s_fv = fetch_valid;
    s_fx = fetch_x; s_fy = fetch_y; s_sc = scanline;
    s_vb = vblank; s_fs = frame_start; s_li = line_irq;
    s_hs = hsync; s_vs = vsync; s_de = de;
    act = {s_busy, s_fv, s_fx, s_fy, s_sc, s_vb,
           s_fs, s_li, s_hs, s_vs, s_de};
    chk("model", 64'(act), 64'(model_out()));
    @(posedge clock);
    model_edge();
  endtask

  task automatic idle();
    step(0, 1, 0, 0, 0, 0);
  endtask

  task automatic run_to(input int t);
    int g;
    g = 0;
    while (m_t != t && g < 3000) begin
      idle();
      g++;
    end
    if (m_t != t) chk("run_to_timeout", 64'(m_t), 64'(t));
  endtask

  task automatic wait_busy_clear();
    int g;
    g = 0;
    do begin
      idle();
      g++;
    end while (s_busy && g < 400);
    chk("busy_clear", 64'(s_busy), 64'(0));
  endtask

  typedef struct {
    int   k;
    logic fv, fs, de, hs, vs, vb;
    int   fx;
  } vec_t;

  vec_t tbl [14];
  int   small_tm [8];
  int   fxe [8];
  int   n, cnt, at;

  initial begin
    errors = 0;
    checks = 0;
    small_tm = '{8, 2, 3, 1, 4, 1, 2, 1};
    fxe = '{0, 0, 1, 1, 2, 2, 3, 3};
    // k = cycles since enable rose; H 8/2/3/1, V 4/1/2/1, PIPE 2.
    tbl = '{
      '{  0, 1, 1, 0, 1, 0, 0,  0},
      '{  7, 1, 0, 1, 1, 0, 0,  7},
      '{  8, 0, 0, 1, 1, 0, 0,  8},
      '{ 10, 0, 0, 0, 1, 0, 0, 10},
      '{ 12, 0, 0, 0, 0, 0, 0, 12},
      '{ 14, 1, 0, 0, 0, 0, 0,  0},
      '{ 15, 1, 0, 0, 1, 0, 0,  1},
      '{ 16, 1, 0, 1, 1, 0, 0,  2},
      '{ 56, 0, 0, 0, 0, 0, 1,  0},
      '{ 70, 0, 0, 0, 0, 0, 1,  0},
      '{ 72, 0, 0, 0, 1, 1, 1,  2},
      '{ 98, 0, 0, 0, 0, 1, 1,  0},
      '{100, 0, 0, 0, 1, 0, 1,  2},
      '{112, 1, 1, 0, 0, 0, 0,  0}
    };

    reset = 1'b1;
    enable = 1'b0;
    cfg_bus.cfg_we = 1'b0;
    cfg_bus.cfg_sel = '0;
    cfg_bus.cfg_wdata = '0;
    cfg_bus.cfg_commit = 1'b0;
    repeat (2) @(posedge clock);
    model_reset();

    // Reset state
    step(0, 0, 0, 0, 0, 0);
    chk("rst_busy", 64'(s_busy), 64'(0));
    chk("rst_de", 64'(s_de), 64'(0));
    chk("rst_hsync", 64'(s_hs), 64'(1));
    chk("rst_vsync", 64'(s_vs), 64'(0));
    chk("rst_fs", 64'(s_fs), 64'(0));
    chk("rst_li", 64'(s_li), 64'(0));

    // Program the small timing while stopped; commit loads at once.
    for (int i = 0; i < 8; i++) step(0, 0, 1, i, small_tm[i], 0);
    step(0, 0, 1, 8, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("stopped_commit_busy", 64'(s_busy), 64'(1));

    // Small frame against the constant table
    for (int k = 0; k <= 112; k++) begin
      idle();
      for (int j = 0; j < 14; j++) begin
        if (tbl[j].k == k) begin
          chk($sformatf("tbl_fv_k%0d", k), 64'(s_fv), 64'(tbl[j].fv));
          chk($sformatf("tbl_fs_k%0d", k), 64'(s_fs), 64'(tbl[j].fs));
          chk($sformatf("tbl_de_k%0d", k), 64'(s_de), 64'(tbl[j].de));
          chk($sformatf("tbl_hs_k%0d", k), 64'(s_hs), 64'(tbl[j].hs));
          chk($sformatf("tbl_vs_k%0d", k), 64'(s_vs), 64'(tbl[j].vs));
          chk($sformatf("tbl_vb_k%0d", k), 64'(s_vb), 64'(tbl[j].vb));
          chk($sformatf("tbl_fx_k%0d", k), 64'(s_fx), 64'(tbl[j].fx));
        end
      end
    end

    // Deferred commit at y=2: write and commit in one cycle
    run_to(28);
    step(0, 1, 1, 0, 6, 1);
    run_to(111);
    idle();
    chk("defer_busy_at_wrap", 64'(s_busy), 64'(1));
    idle();
    chk("defer_busy_after", 64'(s_busy), 64'(0));
    chk("defer_fs", 64'(s_fs), 64'(1));
    n = 0;
    do begin
      idle();
      n++;
    end while (!s_fs && n < 400);
    chk("frame_len_96", 64'(n), 64'(96));

    // Pixel-repeat scaling
    step(0, 1, 1, 0, 8, 0);
    step(0, 1, 1, 8, 'h11, 1);
    wait_busy_clear();
    chk("rep_fx0", 64'(s_fx), 64'(fxe[0]));
    for (int i = 1; i < 8; i++) begin
      idle();
      chk($sformatf("rep_fx%0d", i), 64'(s_fx), 64'(fxe[i]));
    end
    for (int l = 1; l <= 4; l++) begin
      run_to(l * 14);
      idle();
      chk($sformatf("rep_fy_l%0d", l), 64'(s_fy), 64'(l / 2));
      chk($sformatf("rep_sc_l%0d", l), 64'(s_sc),
          64'((l < 4) ? l : 0));
    end

    // Line interrupt on line 3, then out of range
    step(0, 1, 1, 9, 3, 1);
    wait_busy_clear();
    cnt = s_li ? 1 : 0;
    at = -1;
    for (int i = 1; i < 112; i++) begin
      idle();
      if (s_li) begin
        cnt++;
        at = i;
      end
    end
    chk("irq3_count", 64'(cnt), 64'(1));
    chk("irq3_pos", 64'(at), 64'(42));
    step(0, 1, 1, 9, 9, 1);
    wait_busy_clear();
    cnt = s_li ? 1 : 0;
    for (int i = 1; i < 112; i++) begin
      idle();
      if (s_li) cnt++;
    end
    chk("irq9_count", 64'(cnt), 64'(0));

    // Enable drop at x=5, y=1
    run_to(19);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("drop_de", 64'(s_de), 64'(0));
    chk("drop_hsync", 64'(s_hs), 64'(1));
    chk("drop_vsync", 64'(s_vs), 64'(0));
    chk("drop_fv", 64'(s_fv), 64'(0));
    idle();
    chk("reen_fs", 64'(s_fs), 64'(1));
    chk("reen_fx", 64'(s_fx), 64'(0));
    chk("reen_fy", 64'(s_fy), 64'(0));

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int s, d;
      s = $urandom_range(0, 15);
      if (s == 8) d = $urandom_range(0, 127);
      else if (s == 9) d = $urandom_range(0, 12);
      else d = $urandom_range(0, 5);
      step($urandom_range(0, 499) == 0, $urandom_range(0, 49) != 0,
           $urandom_range(0, 9) == 0, s, d,
           $urandom_range(0, 29) == 0);
    end

    // Reset with a pending commit restores defaults
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 20, 1);
    idle();
    chk("pre_rst_busy", 64'(s_busy), 64'(1));
    step(1, 1, 0, 0, 0, 0);
    for (int k = 0; k <= 1712; k++) begin
      idle();
      if (k == 0) begin
        chk("post_rst_busy", 64'(s_busy), 64'(0));
        chk("post_rst_fs", 64'(s_fs), 64'(1));
      end
      if (k == 1361) chk("def_hs_1361", 64'(s_hs), 64'(1));
      if (k == 1362) chk("def_hs_1362", 64'(s_hs), 64'(0));
      if (k == 1711) begin
        chk("def_fv_1711", 64'(s_fv), 64'(0));
        chk("def_sc_1711", 64'(s_sc), 64'(0));
      end
      if (k == 1712) begin
        chk("def_fv_1712", 64'(s_fv), 64'(1));
        chk("def_sc_1712", 64'(s_sc), 64'(1));
        chk("def_fx_1712", 64'(s_fx), 64'(0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised, runtime-programmable VGA/raster timing generator.
- Produces fetch-side pixel coordinates for a frame buffer, plus hsync/vsync/de outputs delayed by a configurable pipeline depth so they line up with memory and palette read latency.
- Timings, pixel-repeat scaling and a line interrupt are programmable through a shadow register set that applies atomically at a frame boundary.
- Sits between the peripheral bus register block and the VRAM/palette read path; runs entirely in the pixel clock domain.

Parameters:
- CW, 12, width of the x/y counters and timing fields.
- PIPE, 2, cycles from fetch outputs to sync/de outputs; range 1..8.
- H_ACTIVE, H_FRONT, H_SYNC, H_BACK: 1280, 80, 136, 216; reset horizontal timing in pixels.
- V_ACTIVE, V_FRONT, V_SYNC, V_BACK: 960, 1, 3, 30; reset vertical timing in lines.
- X_SHIFT, Y_SHIFT, 1, 1; reset pixel-repeat shifts, range 0..7.
- HS_ACT_HIGH, 0, hsync active level.
- VS_ACT_HIGH, 1, vsync active level.

Ports:
- clock  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 runs the timing generator.
- cfg_we  in  1  write strobe for a shadow register.
- cfg_sel  in  4  register select: 0-3 H active/front/sync/back; 4-7 V active/front/sync/back; 8 {Y_SHIFT[6:4], X_SHIFT[2:0]}; 9 irq_line.
- cfg_wdata  in  CW  write data.
- cfg_commit  in  1  request to apply the shadow set to the live set.
- cfg_busy  out  1  a commit is pending.
- fetch_valid  out  1  current counter position is in the active area.
- fetch_x  out  CW  x >> x_shift.
- fetch_y  out  CW  y >> y_shift.
- scanline  out  CW  y while in the active area, else 0.
- vblank  out  1  y >= v_active.
- frame_start  out  1  1-cycle pulse at x=0, y=0.
- line_irq  out  1  1-cycle pulse at x=0, y=irq_line.
- hsync  out  1  horizontal sync, delayed PIPE cycles.
- vsync  out  1  vertical sync, delayed PIPE cycles.
- de  out  1  data enable, delayed PIPE cycles.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - Counters x=0, y=0.
  - Shadow and live registers take their parameter defaults; irq_line=0.
  - cfg_busy=0, de=0, frame_start=0, line_irq=0.
  - hsync and vsync at their inactive levels; the whole delay pipeline is cleared.
- Horizontal line layout: active [0, ha), front porch, sync, back porch; h_total = ha+hf+hs+hb.
- Vertical frame layout: same order in lines; v_total = va+vf+vs+vb.
- Counter stepping: x increments every cycle and wraps at h_total-1 to 0. y increments on each x wrap and wraps at v_total-1 to 0.
- Fetch outputs are combinational from the live counters and live registers (cycle n):
  - fetch_valid = (x < ha) && (y < va).
  - frame_start and line_irq assert only while enable=1.
  - An irq_line >= v_total never fires.
- Delayed outputs at cycle n+PIPE:
  - de = fetch_valid.
  - hsync is active for ha+hf <= x < ha+hf+hs.
  - vsync is active for the same range on y.
- enable=0:
  - Counters are forced to 0 and held.
  - fetch_valid, frame_start and line_irq are 0.
  - The delay pipeline is flushed, so de=0 and syncs are inactive starting the next cycle.
  - On re-enable, the first cycle is x=0, y=0 and frame_start pulses.
- Config writes:
  - cfg_we writes the shadow register only; the live set is untouched.
  - A timing field written as 0 is stored as 1.
  - Shift values above 7 are impossible because the fields are 3 bits.
  - cfg_sel 10-15 are ignored.
- Commit:
  - cfg_commit sets a pending flag; cfg_busy=1.
  - The live set loads from the shadow on the cycle where x=h_total-1 and y=v_total-1, together with the wrap to 0, so the next frame uses the new timing. The pending flag clears on that same edge.
  - If enable=0, the load happens on the next edge.
  - cfg_we and cfg_commit in the same cycle: the write lands in the shadow first and is included in the commit.
  - A commit while one is already pending is absorbed.
  - Writes while pending are allowed and are taken by the pending commit.
- Reset mid-frame discards any pending commit and shadow edits.
- Counter widths: every comparison uses CW bits. h_total and v_total must fit in CW bits; overflow is outside the contract and is not checked.

Test Plan:
- Small-timing frame:
  - Stimulus: live timings H 8/2/3/1 and V 4/1/2/1, shifts 0, PIPE=2, enable=1 after reset.
  - Required: h_total=14 and a frame of 112 cycles.
  - Required: fetch_valid for x 0..7 on lines 0..3.
  - Required: de is the same pattern shifted by 2 cycles.
  - Required: hsync is active for x 10..12 shifted by 2; vsync is active on lines 5..6.
  - Required: frame_start pulses every 112 cycles.
- Deferred commit:
  - Stimulus: at y=2, write sel0=6 and pulse cfg_commit.
  - Required: cfg_busy stays 1 until the wrap at (13,7).
  - Required: the current frame keeps 14-cycle lines; the next frame has 12-cycle lines and a 96-cycle frame.
- Pixel-repeat scaling:
  - Stimulus: sel8=0x11, then commit.
  - Required: fetch_x reads 0,0,1,1,2,2,3,3 across each active line.
  - Required: fetch_y steps every 2 lines; scanline shows the raw y.
- Line interrupt:
  - Stimulus: irq_line=3.
  - Required: exactly one line_irq pulse per frame, at x=0, y=3.
  - Stimulus: irq_line=9.
  - Required: no pulse.
- Enable drop:
  - Stimulus: drop enable at x=5, y=1.
  - Required: de=0 and syncs inactive from the next cycle.
  - Stimulus: raise enable again.
  - Required: frame_start pulses on the first enabled cycle with x=0, y=0.
- Reset with pending commit:
  - Stimulus: pending commit, then reset for 1 cycle.
  - Required: cfg_busy=0 and the live timings return to the parameter defaults (h_total=1712).
